// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for decode, execute and writeback:
// opcodes, ALU operations, memory sizes, writeback and jump selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_MUL   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_SL    = 4'd5;
    localparam logic [3:0] ALU_SR    = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLTU  = 4'd8;
    localparam logic [3:0] ALU_AUIPC = 4'd9;
    localparam logic [3:0] ALU_XOR   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] JUMP_NONE   = 2'b00;
    localparam logic [1:0] JUMP_BRANCH = 2'b01;
    localparam logic [1:0] JUMP_JAL    = 2'b10;
    localparam logic [1:0] JUMP_JALR   = 2'b11;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_arith;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_unsigned;
        logic [1:0] mem_size;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] jump;
        logic [2:0] branch_f3;
        logic       illegal;
    } ctrl_t;

    // ALU operation shared by OP and OP-IMM for a given funct3 (ADD/SR variants resolved by caller).
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SR;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Load/store access size from the low funct3 bits.
    function automatic logic [1:0] mem_size_from_f3(input logic [2:0] f3);
        logic [1:0] sz;
        case (f3[1:0])
            2'b00:   sz = MEM_SIZE_BYTE;
            2'b01:   sz = MEM_SIZE_HALF;
            default: sz = MEM_SIZE_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Format-driven immediate extractor; sign-extends the I/S/B/U/J immediate
// of an instruction word. Also used by the branch predictor.
module id_imm_gen
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Select and sign-extend the immediate field for the given format.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            IMM_S: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-20){inst[31]}}, inst[31:12]} << 12;
            IMM_J: imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I (+ optional MUL) decode stage with valid/ready handshake,
// one-bubble load-use stall and illegal-encoding reporting.
module id_decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENABLE_M  = 0,
    parameter int HAZARD_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_arith,
    output logic            out_alu_src,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_mem_unsigned,
    output logic [1:0]      out_mem_size,
    output logic            out_reg_write,
    output logic [1:0]      out_mem_to_reg,
    output logic [1:0]      out_jump,
    output logic [2:0]      out_branch_f3,
    output logic            out_illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opc = in_inst[6:0];
    assign rd  = in_inst[11:7];
    assign f3  = in_inst[14:12];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign f7  = in_inst[31:25];

    ctrl_t           ctrl_d;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm_d;
    logic            legal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            std_f7;
    logic            hazard;

    ctrl_t           ctrl_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rd_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;

    assign std_f7 = (f7 == 7'b0000000) || (f7 == 7'b0100000);

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (in_inst),
        .fmt  (fmt),
        .imm  (imm_d)
    );

    // Decode the offered instruction into a control bundle, immediate format and operand usage.
    always_comb begin
        ctrl_d   = '0;
        fmt      = IMM_NONE;
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opc)
            OPC_LUI: begin
                ctrl_d.alu_op    = ALU_PASSB;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                fmt              = IMM_U;
                uses_rs1         = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl_d.alu_op    = ALU_AUIPC;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                fmt              = IMM_U;
                uses_rs1         = 1'b0;
            end
            OPC_JAL: begin
                ctrl_d.alu_op     = ALU_ADD;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = WB_PC4;
                ctrl_d.jump       = JUMP_JAL;
                fmt               = IMM_J;
                uses_rs1          = 1'b0;
            end
            OPC_JALR: begin
                ctrl_d.alu_op     = ALU_ADD;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = WB_PC4;
                ctrl_d.jump       = JUMP_JALR;
                fmt               = IMM_I;
                legal             = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                ctrl_d.alu_op = ALU_SUB;
                ctrl_d.jump   = JUMP_BRANCH;
                fmt           = IMM_B;
                uses_rs2      = 1'b1;
                legal         = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_LOAD: begin
                ctrl_d.alu_op       = ALU_ADD;
                ctrl_d.alu_src      = 1'b1;
                ctrl_d.mem_read     = 1'b1;
                ctrl_d.reg_write    = 1'b1;
                ctrl_d.mem_to_reg   = WB_MEM;
                ctrl_d.mem_size     = mem_size_from_f3(f3);
                ctrl_d.mem_unsigned = f3[2];
                fmt                 = IMM_I;
                legal               = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            OPC_STORE: begin
                ctrl_d.alu_op    = ALU_ADD;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.mem_size  = mem_size_from_f3(f3);
                fmt              = IMM_S;
                uses_rs2         = 1'b1;
                legal            = (f3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                ctrl_d.alu_op    = alu_op_from_f3(f3);
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_arith = (f3 == 3'b101) && f7[5];
                fmt              = IMM_I;
                // funct7 only qualifies the shift-immediate forms; elsewhere it is immediate data.
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    legal = std_f7;
                end
            end
            OPC_OP: begin
                ctrl_d.reg_write = 1'b1;
                uses_rs2         = 1'b1;
                if (f7 == 7'b0000001) begin
                    ctrl_d.alu_op = ALU_MUL;
                    legal         = (ENABLE_M != 0) && (f3 == 3'b000);
                end else begin
                    ctrl_d.alu_op    = ((f3 == 3'b000) && f7[5]) ? ALU_SUB : alu_op_from_f3(f3);
                    ctrl_d.alu_arith = (f3 == 3'b101) && f7[5];
                    legal            = std_f7;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        if (!legal) begin
            ctrl_d.reg_write = 1'b0;
            ctrl_d.mem_read  = 1'b0;
            ctrl_d.mem_write = 1'b0;
            ctrl_d.jump      = JUMP_NONE;
        end
        if (rd == 5'd0) begin
            ctrl_d.reg_write = 1'b0;
        end
        ctrl_d.illegal   = !legal;
        ctrl_d.branch_f3 = f3;
    end

    // Load-use stall: the held load writes a register the offered instruction reads.
    always_comb begin
        hazard = (HAZARD_EN != 0) && valid_q && ctrl_q.mem_read && (rd_q != 5'd0) && in_valid &&
                 ((uses_rs1 && (rs1 == rd_q)) || (uses_rs2 && (rs2 == rd_q)));
    end

    assign in_ready = !reset && !flush && (!valid_q || out_ready) && !hazard;

    // Pipeline register: reset/flush, bubble on hazard, load on accept, drain on consume, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (hazard && out_ready) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            pc_q    <= in_pc;
            imm_q   <= imm_d;
            rd_q    <= rd;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid        = valid_q;
    assign out_pc           = pc_q;
    assign out_rd           = rd_q;
    assign out_rs1          = rs1_q;
    assign out_rs2          = rs2_q;
    assign out_imm          = imm_q;
    assign out_alu_op       = ctrl_q.alu_op;
    assign out_alu_arith    = ctrl_q.alu_arith;
    assign out_alu_src      = ctrl_q.alu_src;
    assign out_mem_read     = ctrl_q.mem_read;
    assign out_mem_write    = ctrl_q.mem_write;
    assign out_mem_unsigned = ctrl_q.mem_unsigned;
    assign out_mem_size     = ctrl_q.mem_size;
    assign out_reg_write    = ctrl_q.reg_write;
    assign out_mem_to_reg   = ctrl_q.mem_to_reg;
    assign out_jump         = ctrl_q.jump;
    assign out_branch_f3    = ctrl_q.branch_f3;
    assign out_illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: two instances (base with hazard detection,
// and MUL-enabled without hazard detection) share one input stream and
// are each checked against an instruction-level reference model.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        rdy_w [2];
    logic        o_valid [2];
    logic [31:0] o_pc [2];
    logic [31:0] o_imm [2];
    logic [4:0]  o_rd [2];
    logic [4:0]  o_rs1 [2];
    logic [4:0]  o_rs2 [2];
    logic [3:0]  o_op [2];
    logic        o_ar [2];
    logic        o_src [2];
    logic        o_mr [2];
    logic        o_mw [2];
    logic        o_mu [2];
    logic [1:0]  o_ms [2];
    logic        o_rw [2];
    logic [1:0]  o_wb [2];
    logic [1:0]  o_jp [2];
    logic [2:0]  o_f3 [2];
    logic        o_ill [2];

    always #5 clk = ~clk;

    id_decode_stage #(.XLEN(32), .ENABLE_M(0), .HAZARD_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[0]),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_pc(o_pc[0]),
        .out_rd(o_rd[0]), .out_rs1(o_rs1[0]), .out_rs2(o_rs2[0]), .out_imm(o_imm[0]),
        .out_alu_op(o_op[0]), .out_alu_arith(o_ar[0]), .out_alu_src(o_src[0]),
        .out_mem_read(o_mr[0]), .out_mem_write(o_mw[0]), .out_mem_unsigned(o_mu[0]),
        .out_mem_size(o_ms[0]), .out_reg_write(o_rw[0]), .out_mem_to_reg(o_wb[0]),
        .out_jump(o_jp[0]), .out_branch_f3(o_f3[0]), .out_illegal(o_ill[0])
    );

    id_decode_stage #(.XLEN(32), .ENABLE_M(1), .HAZARD_EN(0)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w[1]),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_pc(o_pc[1]),
        .out_rd(o_rd[1]), .out_rs1(o_rs1[1]), .out_rs2(o_rs2[1]), .out_imm(o_imm[1]),
        .out_alu_op(o_op[1]), .out_alu_arith(o_ar[1]), .out_alu_src(o_src[1]),
        .out_mem_read(o_mr[1]), .out_mem_write(o_mw[1]), .out_mem_unsigned(o_mu[1]),
        .out_mem_size(o_ms[1]), .out_reg_write(o_rw[1]), .out_mem_to_reg(o_wb[1]),
        .out_jump(o_jp[1]), .out_branch_f3(o_f3[1]), .out_illegal(o_ill[1])
    );

    typedef struct {
        logic        ill;
        logic        dc;   // illegal: only the forced/raw fields are defined
        logic [3:0]  op;
        logic        ar, src, mr, mw, mu, rw;
        logic [1:0]  ms, wb, jp;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    bit   em [2] = '{1'b0, 1'b1};
    bit   he [2] = '{1'b1, 1'b0};
    bit   mv [2];
    exp_t mb [2];
    bit   exp_hz [2];
    bit   exp_rdy [2];
    logic [3:0] f3_op [8] = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd10, 4'd6, 4'd4, 4'd3};
    logic [6:0] opc_pool [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t zero_b();
        exp_t z;
        z = '{default: '0};
        return z;
    endfunction

    // Meaning of an instruction word as RV32I(+M) defines it.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit en_m);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit std7;
        e = zero_b();
        f3 = w[14:12];
        f7 = w[31:25];
        std7 = (f7 == 7'h00) || (f7 == 7'h20);
        e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = f3; e.pc = pc;
        case (w[6:0])
            7'h37: begin e.op = 11; e.src = 1; e.rw = 1; e.imm = {w[31:12], 12'h000}; end
            7'h17: begin e.op = 9;  e.src = 1; e.rw = 1; e.imm = {w[31:12], 12'h000}; end
            7'h6f: begin
                e.src = 1; e.rw = 1; e.wb = 2; e.jp = 2;
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            end
            7'h67: begin
                e.src = 1; e.rw = 1; e.wb = 2; e.jp = 3; e.ill = (f3 != 0);
                e.imm = 32'($signed(w[31:20]));
            end
            7'h63: begin
                e.op = 1; e.jp = 1; e.ill = (f3 == 2) || (f3 == 3);
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            end
            7'h03: begin
                e.src = 1; e.mr = 1; e.rw = 1; e.wb = 1;
                e.ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
                e.ms = (f3[1:0] == 0) ? 2'd2 : (f3[1:0] == 1) ? 2'd1 : 2'd0;
                e.mu = (f3 == 4) || (f3 == 5);
                e.imm = 32'($signed(w[31:20]));
            end
            7'h23: begin
                e.src = 1; e.mw = 1; e.ill = (f3 > 2);
                e.ms = (f3 == 0) ? 2'd2 : (f3 == 1) ? 2'd1 : 2'd0;
                e.imm = 32'($signed({w[31:25], w[11:7]}));
            end
            7'h13: begin
                e.src = 1; e.rw = 1; e.op = f3_op[f3];
                e.imm = 32'($signed(w[31:20]));
                if (f3 == 1 || f3 == 5) e.ill = !std7;
                e.ar = (f3 == 5) && f7[5];
            end
            7'h33: begin
                e.rw = 1;
                if (f7 == 7'h01) begin
                    e.op = 2; e.ill = !(en_m && f3 == 0);
                end else begin
                    e.ill = !std7;
                    e.op = (f3 == 0 && f7[5]) ? 4'd1 : f3_op[f3];
                    e.ar = (f3 == 5) && f7[5];
                end
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin
            e.dc = 1; e.rw = 0; e.mr = 0; e.mw = 0; e.jp = 0;
        end
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        bit r1, r2;
        r1 = !(w[6:0] == 7'h37 || w[6:0] == 7'h17 || w[6:0] == 7'h6f);
        r2 = (w[6:0] == 7'h33 || w[6:0] == 7'h23 || w[6:0] == 7'h63);
        return (r1 && w[19:15] == r) || (r2 && w[24:20] == r);
    endfunction

    task automatic check_outputs(input int d);
        exp_t e;
        e = mb[d];
        chk($sformatf("d%0d_valid", d), o_valid[d], mv[d]);
        chk($sformatf("d%0d_pc", d), o_pc[d], e.pc);
        chk($sformatf("d%0d_rd", d), o_rd[d], e.rd);
        chk($sformatf("d%0d_rs1", d), o_rs1[d], e.rs1);
        chk($sformatf("d%0d_rs2", d), o_rs2[d], e.rs2);
        chk($sformatf("d%0d_imm", d), o_imm[d], e.imm);
        chk($sformatf("d%0d_illegal", d), o_ill[d], e.ill);
        chk($sformatf("d%0d_reg_write", d), o_rw[d], e.rw);
        chk($sformatf("d%0d_mem_read", d), o_mr[d], e.mr);
        chk($sformatf("d%0d_mem_write", d), o_mw[d], e.mw);
        chk($sformatf("d%0d_jump", d), o_jp[d], e.jp);
        chk($sformatf("d%0d_branch_f3", d), o_f3[d], e.f3);
        if (!e.dc) begin
            chk($sformatf("d%0d_alu_op", d), o_op[d], e.op);
            chk($sformatf("d%0d_alu_arith", d), o_ar[d], e.ar);
            chk($sformatf("d%0d_alu_src", d), o_src[d], e.src);
            chk($sformatf("d%0d_mem_unsigned", d), o_mu[d], e.mu);
            chk($sformatf("d%0d_mem_size", d), o_ms[d], e.ms);
            chk($sformatf("d%0d_mem_to_reg", d), o_wb[d], e.wb);
        end
    endtask

    // One clock: check handshake before the edge, advance the model, check the register after it.
    task automatic cycle();
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_hz[d] = he[d] && mv[d] && mb[d].mr && (mb[d].rd != 0) && in_valid &&
                        reads_reg(in_inst, mb[d].rd);
            exp_rdy[d] = !reset && !flush && (!mv[d] || out_ready) && !exp_hz[d];
            chk($sformatf("d%0d_in_ready", d), rdy_w[d], exp_rdy[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                mv[d] = 0; mb[d] = zero_b();
            end else if (flush) begin
                mv[d] = 0;
            end else if (exp_hz[d] && out_ready) begin
                mv[d] = 0;
            end else if (in_valid && exp_rdy[d]) begin
                mv[d] = 1; mb[d] = ref_decode(in_inst, in_pc, em[d]);
            end else if (out_ready) begin
                mv[d] = 0;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opc, f7;
        logic [4:0] r1, r2, rdv;
        int k;
        k = $urandom_range(0, 9);
        opc = (k < 9) ? opc_pool[k] : 7'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        rdv = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        return {f7, r2, r1, 3'($urandom_range(0, 7)), rdv, opc};
    endfunction

    initial begin
        mv[0] = 0; mv[1] = 0;
        mb[0] = zero_b(); mb[1] = zero_b();

        // Reset held two cycles while fetch offers a load.
        reset = 1; flush = 0; out_ready = 1; in_valid = 1;
        in_inst = 32'h00812283; in_pc = 32'h100;
        cycle();
        cycle();
        chk("reset_out_valid", o_valid[0], 0);
        chk("reset_imm", o_imm[0], 0);

        // lw x5,8(x2)
        reset = 0;
        cycle();
        chk("lw_valid", o_valid[0], 1);
        chk("lw_mem_read", o_mr[0], 1);
        chk("lw_reg_write", o_rw[0], 1);
        chk("lw_alu_src", o_src[0], 1);
        chk("lw_mem_to_reg", o_wb[0], 2'b01);
        chk("lw_mem_size", o_ms[0], 2'b00);
        chk("lw_alu_op", o_op[0], 0);
        chk("lw_imm", o_imm[0], 8);
        chk("lw_rd", o_rd[0], 5);
        chk("lw_rs1", o_rs1[0], 2);

        // add x6,x5,x7 right behind the load: bubble with hazard detection, none without.
        in_inst = 32'h00728333; in_pc = 32'h104;
        cycle();
        chk("hz_bubble", o_valid[0], 0);
        chk("nohz_add_valid", o_valid[1], 1);
        chk("nohz_add_rd", o_rd[1], 6);
        cycle();
        chk("hz_add_valid", o_valid[0], 1);
        chk("hz_add_rd", o_rd[0], 6);
        chk("hz_add_pc", o_pc[0], 32'h104);

        // sra x3,x1,x2
        in_inst = 32'h4020D1B3; in_pc = 32'h108;
        cycle();
        chk("sra_alu_op", o_op[0], 6);
        chk("sra_arith", o_ar[0], 1);
        chk("sra_alu_src", o_src[0], 0);

        // mul x1,x2,x3
        in_inst = 32'h023100B3; in_pc = 32'h10C;
        cycle();
        chk("mul_off_illegal", o_ill[0], 1);
        chk("mul_off_reg_write", o_rw[0], 0);
        chk("mul_on_alu_op", o_op[1], 2);
        chk("mul_on_illegal", o_ill[1], 0);

        // addi x1,x0,5 then backpressure for three cycles.
        in_inst = 32'h00500093; in_pc = 32'h200;
        cycle();
        out_ready = 0; in_inst = 32'h00728333; in_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_valid", o_valid[0], 1);
            chk("bp_imm", o_imm[0], 5);
            chk("bp_rd", o_rd[0], 1);
            chk("bp_pc", o_pc[0], 32'h200);
        end
        flush = 1;
        cycle();
        chk("flush_valid", o_valid[0], 0);
        chk("flush_valid_m", o_valid[1], 0);
        flush = 0; in_valid = 0; out_ready = 1;
        cycle();
        chk("flush_dropped", o_valid[0], 0);

        // Randomized stream.
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_inst   = rand_inst();
            in_pc     = {$urandom, 2'b00};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
